// File: rtl/ras_stack.sv
// ras_stack: return-address stack for call/return prediction.
//
// A circular array of return addresses with a top pointer and an occupancy
// counter. Pushing onto a full stack overwrites the oldest entry. A restore
// reloads the pointer and counter from a checkpoint and leaves the array
// contents alone.
//
// Configuration macro: RAS_EMPTY_POP_GUARD_EN
//   defined   : a pop on an empty stack forces ras_ret_address to 0 in that
//               cycle and leaves the pointer where it is.
//   undefined : a pop on an empty stack returns the stale top entry and
//               moves the pointer down with wrap; the count stays at 0.
//
// Ports:
//   CLK             in   clock, rising edge
//   nRST            in   asynchronous active-low reset
//   push_valid      in   a call was predicted this cycle
//   push_address    in   return address to push
//   pop_valid       in   a return was predicted this cycle
//   restore_valid   in   reload pointer/count from a checkpoint (highest priority)
//   restore_index   in   checkpointed top pointer
//   restore_count   in   checkpointed occupancy (clamped to RAS_ENTRIES)
//   ras_ret_address out  current top-of-stack entry (combinational read)
//   ras_index       out  current top pointer
//   ras_count       out  current occupancy, 0..RAS_ENTRIES
//   ras_empty       out  occupancy is zero
module ras_stack #(
    parameter int RAS_ENTRIES      = 8,
    parameter int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
    parameter int RAS_TARGET_WIDTH = 31
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        push_valid,
    input  logic [RAS_TARGET_WIDTH-1:0] push_address,
    input  logic                        pop_valid,
    input  logic                        restore_valid,
    input  logic [RAS_INDEX_WIDTH-1:0]  restore_index,
    input  logic [RAS_INDEX_WIDTH:0]    restore_count,
    output logic [RAS_TARGET_WIDTH-1:0] ras_ret_address,
    output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
    output logic [RAS_INDEX_WIDTH:0]    ras_count,
    output logic                        ras_empty
);

    localparam logic [RAS_INDEX_WIDTH:0]   COUNT_FULL = (RAS_INDEX_WIDTH+1)'(RAS_ENTRIES);
    localparam logic [RAS_INDEX_WIDTH:0]   COUNT_ONE  = 1;
    localparam logic [RAS_INDEX_WIDTH:0]   COUNT_ZERO = '0;
    localparam logic [RAS_INDEX_WIDTH-1:0] PTR_ONE    = 1;

    logic [RAS_TARGET_WIDTH-1:0] stack_q [RAS_ENTRIES];
    logic [RAS_TARGET_WIDTH-1:0] stack_d [RAS_ENTRIES];
    logic [RAS_INDEX_WIDTH-1:0]  ptr_q;
    logic [RAS_INDEX_WIDTH-1:0]  ptr_d;
    logic [RAS_INDEX_WIDTH:0]    count_q;
    logic [RAS_INDEX_WIDTH:0]    count_d;

    logic [RAS_INDEX_WIDTH-1:0]  ptr_inc;
    logic [RAS_INDEX_WIDTH-1:0]  ptr_dec;

    // Pointer width equals log2(depth), so plain binary add/sub wraps
    // modulo RAS_ENTRIES.
    assign ptr_inc = ptr_q + PTR_ONE;
    assign ptr_dec = ptr_q - PTR_ONE;

    always_comb begin
        stack_d = stack_q;
        ptr_d   = ptr_q;
        count_d = count_q;

        if (restore_valid) begin
            ptr_d   = restore_index;
            count_d = (restore_count > COUNT_FULL) ? COUNT_FULL : restore_count;
        end else if (push_valid && pop_valid) begin
            // Return immediately followed by a call: replace the top in place.
            stack_d[ptr_q] = push_address;
            count_d        = (count_q == COUNT_ZERO) ? COUNT_ONE : count_q;
        end else if (push_valid) begin
            // When full, ptr_inc lands on the oldest entry and overwrites it.
            stack_d[ptr_inc] = push_address;
            ptr_d            = ptr_inc;
            count_d          = (count_q == COUNT_FULL) ? count_q : count_q + COUNT_ONE;
        end else if (pop_valid) begin
            if (count_q != COUNT_ZERO) begin
                ptr_d   = ptr_dec;
                count_d = count_q - COUNT_ONE;
            end else begin
`ifdef RAS_EMPTY_POP_GUARD_EN
                ptr_d   = ptr_q;
`else
                ptr_d   = ptr_dec;
`endif
                count_d = COUNT_ZERO;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                stack_q[i] <= '0;
            end
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            stack_q <= stack_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

`ifdef RAS_EMPTY_POP_GUARD_EN
    logic empty_pop;

    // Only a pure pop counts; restore or a paired push make the pop harmless.
    assign empty_pop       = pop_valid && !push_valid && !restore_valid &&
                             (count_q == COUNT_ZERO);
    assign ras_ret_address = empty_pop ? '0 : stack_q[ptr_q];
`else
    assign ras_ret_address = stack_q[ptr_q];
`endif

    assign ras_index = ptr_q;
    assign ras_count = count_q;
    assign ras_empty = (count_q == COUNT_ZERO);

endmodule

// File: tb/tb_ras_stack.sv
module tb_ras_stack;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        push_valid;
    logic [30:0] push_address;
    logic        pop_valid;
    logic        restore_valid;
    logic [2:0]  restore_index;
    logic [3:0]  restore_count;
    logic [30:0] ras_ret_address;
    logic [2:0]  ras_index;
    logic [3:0]  ras_count;
    logic        ras_empty;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    ras_stack dut (
        .CLK             (CLK),
        .nRST            (nRST),
        .push_valid      (push_valid),
        .push_address    (push_address),
        .pop_valid       (pop_valid),
        .restore_valid   (restore_valid),
        .restore_index   (restore_index),
        .restore_count   (restore_count),
        .ras_ret_address (ras_ret_address),
        .ras_index       (ras_index),
        .ras_count       (ras_count),
        .ras_empty       (ras_empty)
    );

    typedef struct {
        string       name;
        logic        push;
        logic [30:0] addr;
        logic        pop;
        logic        rv;
        logic [2:0]  ridx;
        logic [3:0]  rcnt;
        logic [30:0] e_ret;
        logic [2:0]  e_idx;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic vec_t mk(input string name, input logic push, input logic [30:0] addr,
                                input logic pop, input logic rv, input logic [2:0] ridx,
                                input logic [3:0] rcnt, input logic [30:0] e_ret,
                                input logic [2:0] e_idx, input logic [3:0] e_cnt);
        vec_t v;
        v.name = name; v.push = push; v.addr = addr; v.pop = pop; v.rv = rv;
        v.ridx = ridx; v.rcnt = rcnt; v.e_ret = e_ret; v.e_idx = e_idx; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        push_valid    = 1'b0;
        push_address  = '0;
        pop_valid     = 1'b0;
        restore_valid = 1'b0;
        restore_index = '0;
        restore_count = '0;
    endtask

    task automatic chk_state(input string name, input logic [30:0] e_ret,
                             input logic [2:0] e_idx, input logic [3:0] e_cnt);
        chk({name, "/ret"},   32'(ras_ret_address), 32'(e_ret));
        chk({name, "/idx"},   32'(ras_index),       32'(e_idx));
        chk({name, "/cnt"},   32'(ras_count),       32'(e_cnt));
        chk({name, "/empty"}, 32'(ras_empty),       32'(e_cnt == 4'd0));
    endtask

    // Drive one vector for one clock edge; the expectation travels through
    // the scoreboard queue and is compared once the edge has taken effect.
    task automatic step(input vec_t v);
        vec_t cur;
        exp_q.push_back(v);
        push_valid    = v.push;
        push_address  = v.addr;
        pop_valid     = v.pop;
        restore_valid = v.rv;
        restore_index = v.ridx;
        restore_count = v.rcnt;
        @(posedge CLK);
        #1;
        idle();
        #1;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard: got empty queue expected entry");
        end else begin
            cur = exp_q.pop_front();
            chk_state(cur.name, cur.e_ret, cur.e_idx, cur.e_cnt);
        end
    endtask

    task automatic do_reset(input string name);
        nRST = 1'b0;
        idle();
        #1;
        chk_state(name, 31'h0, 3'd0, 4'd0);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        nRST = 1'b0;
        idle();
        #2;
        do_reset("reset");

        // Three pushes then three pops, then fill past capacity and drain.
        tbl.push_back(mk("push100", 1, 31'h100, 0, 0, 0, 0, 31'h100, 3'd1, 4'd1));
        tbl.push_back(mk("push200", 1, 31'h200, 0, 0, 0, 0, 31'h200, 3'd2, 4'd2));
        tbl.push_back(mk("push300", 1, 31'h300, 0, 0, 0, 0, 31'h300, 3'd3, 4'd3));
        tbl.push_back(mk("pop_a",   0, 31'h0,   1, 0, 0, 0, 31'h200, 3'd2, 4'd2));
        tbl.push_back(mk("pop_b",   0, 31'h0,   1, 0, 0, 0, 31'h100, 3'd1, 4'd1));
        tbl.push_back(mk("pop_c",   0, 31'h0,   1, 0, 0, 0, 31'h0,   3'd0, 4'd0));
        tbl.push_back(mk("idle",    0, 31'h0,   0, 0, 0, 0, 31'h0,   3'd0, 4'd0));
        for (int k = 1; k <= 9; k++) begin
            tbl.push_back(mk($sformatf("fill%0d", k), 1, 31'(k), 0, 0, 0, 0,
                             31'(k), 3'(k % 8), 4'((k < 8) ? k : 8)));
        end
        for (int j = 1; j <= 8; j++) begin
            tbl.push_back(mk($sformatf("drain%0d", j), 0, 31'h0, 1, 0, 0, 0,
                             31'((j == 8) ? 9 : 9 - j), 3'((9 - j) % 8), 4'(8 - j)));
        end
        foreach (tbl[i]) step(tbl[i]);

        // Ninth pop on an empty stack: stale top is 0x9 at ptr 1.
        pop_valid = 1'b1;
        #1;
`ifdef RAS_EMPTY_POP_GUARD_EN
        chk("empty_pop9/comb_ret", 32'(ras_ret_address), 32'h0);
        step(mk("empty_pop9", 0, 31'h0, 1, 0, 0, 0, 31'h9, 3'd1, 4'd0));
`else
        chk("empty_pop9/comb_ret", 32'(ras_ret_address), 32'h9);
        step(mk("empty_pop9", 0, 31'h0, 1, 0, 0, 0, 31'h8, 3'd0, 4'd0));
`endif

        // Empty pop straight out of reset.
        do_reset("reset2");
        pop_valid = 1'b1;
        #1;
        chk("rst_pop/comb_ret", 32'(ras_ret_address), 32'h0);
`ifdef RAS_EMPTY_POP_GUARD_EN
        step(mk("rst_pop", 0, 31'h0, 1, 0, 0, 0, 31'h0, 3'd0, 4'd0));
`else
        step(mk("rst_pop", 0, 31'h0, 1, 0, 0, 0, 31'h0, 3'd7, 4'd0));
`endif

        // Same-cycle push/pop, checkpoint restore priority and clamping.
        do_reset("reset3");
        step(mk("push10",   1, 31'h10, 0, 0, 0,    0,     31'h10, 3'd2 - 3'd1, 4'd1));
        step(mk("push20",   1, 31'h20, 0, 0, 0,    0,     31'h20, 3'd2, 4'd2));
        step(mk("pushpop",  1, 31'h55, 1, 0, 0,    0,     31'h55, 3'd2, 4'd2));
        step(mk("pushAA",   1, 31'hAA, 0, 0, 0,    0,     31'hAA, 3'd3, 4'd3));
        step(mk("pushBB",   1, 31'hBB, 0, 0, 0,    0,     31'hBB, 3'd4, 4'd4));
        step(mk("restore",  1, 31'hCC, 1, 1, 3'd2, 4'd2,  31'h55, 3'd2, 4'd2));
        step(mk("hold",     0, 31'h0,  0, 0, 0,    0,     31'h55, 3'd2, 4'd2));
        step(mk("rst_clmp", 0, 31'h0,  0, 1, 3'd4, 4'd15, 31'hBB, 3'd4, 4'd8));
        step(mk("rst_pop8", 0, 31'h0,  1, 1, 3'd3, 4'd8,  31'hAA, 3'd3, 4'd8));
        step(mk("rst_zero", 0, 31'h0,  0, 1, 3'd0, 4'd0,  31'h0,  3'd0, 4'd0));
        step(mk("pp_empty", 1, 31'h77, 1, 0, 0,    0,     31'h77, 3'd0, 4'd1));

        // Asynchronous reset in the middle of a push.
        do_reset("reset4");
        for (int k = 1; k <= 5; k++) begin
            step(mk($sformatf("pre%0d", k), 1, 31'(16 * k), 0, 0, 0, 0,
                    31'(16 * k), 3'(k), 4'(k)));
        end
        push_valid   = 1'b1;
        push_address = 31'h999;
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        chk_state("async_rst", 31'h0, 3'd0, 4'd0);
        @(posedge CLK);
        #1;
        chk_state("rst_held", 31'h0, 3'd0, 4'd0);
        @(negedge CLK);
        nRST = 1'b1;
        step(mk("first_edge", 1, 31'h42, 0, 0, 0, 0, 31'h42, 3'd1, 4'd1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ras_stack.md
RAS_STACK -- requirements
Module: ras_stack

Interface
REQ-001: Parameter RAS_ENTRIES, default 8, sets the stack depth. It SHALL be a power of 2 and at least 2.
REQ-002: Parameter RAS_INDEX_WIDTH, default $clog2(RAS_ENTRIES), sets the pointer width.
REQ-003: Parameter RAS_TARGET_WIDTH, default 31, is the return-address width (PC[31:1]).
REQ-004: Port CLK, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005: Port nRST, input, 1 bit: asynchronous, active-low reset.
REQ-006: Port push_valid, input, 1 bit: a call was predicted this cycle.
REQ-007: Port push_address, input, RAS_TARGET_WIDTH bits: the return address to push.
REQ-008: Port pop_valid, input, 1 bit: a return was predicted this cycle.
REQ-009: Port restore_valid, input, 1 bit: repair the stack state after a mispredict or flush.
REQ-010: Port restore_index, input, RAS_INDEX_WIDTH bits: the saved top pointer.
REQ-011: Port restore_count, input, RAS_INDEX_WIDTH+1 bits: the saved occupancy.
REQ-012: Port ras_ret_address, output, RAS_TARGET_WIDTH bits: the current top-of-stack entry; combinational read of the registered array.
REQ-013: Port ras_index, output, RAS_INDEX_WIDTH bits: the current top pointer, for checkpointing.
REQ-014: Port ras_count, output, RAS_INDEX_WIDTH+1 bits: the current occupancy, 0..RAS_ENTRIES.
REQ-015: Port ras_empty, output, 1 bit: asserted when ras_count == 0.

Function
REQ-016: State SHALL be an array stack[RAS_ENTRIES], a top pointer ptr, and an occupancy counter count; ptr arithmetic SHALL wrap modulo RAS_ENTRIES.
REQ-017: ras_ret_address SHALL equal stack[ptr] in the same cycle (0-cycle read); ras_index = ptr; ras_count = count.
REQ-018: Push only: at the edge, stack[ptr+1] <= push_address and ptr <= ptr+1; count <= min(count+1, RAS_ENTRIES).
REQ-019: Push when full SHALL overwrite the oldest entry (circular); count SHALL stay at RAS_ENTRIES.
REQ-020: Pop only with count > 0: ptr <= ptr-1, count <= count-1; the stack contents SHALL be unchanged.
REQ-021: Pop only with count == 0 SHALL follow REQ-032 or REQ-033, depending on configuration.
REQ-022: Push and pop in the same cycle: stack[ptr] <= push_address; ptr is unchanged; count <= max(count, 1).
REQ-023: restore_valid SHALL have the highest priority: ptr <= restore_index and count <= restore_count; push and pop in that cycle SHALL be ignored.
REQ-024: Array contents SHALL NOT be modified by restore.
REQ-025: A restore_count greater than RAS_ENTRIES SHALL be clamped to RAS_ENTRIES.
REQ-026: With no valid input asserted, all state SHALL hold.

Reset
REQ-027: While nRST is low, the following SHALL be held: ptr = 0, count = 0, and every stack entry = 0.
REQ-028: Out of reset, the outputs SHALL be ras_ret_address = 0, ras_index = 0, ras_count = 0, ras_empty = 1.
REQ-029: Reset asserted mid-operation SHALL take effect immediately and asynchronously, discarding any in-flight push, pop, or restore.
REQ-030: The first edge after reset deasserts SHALL process inputs normally.

Configuration
REQ-031: Macro RAS_EMPTY_POP_GUARD_EN selects the empty-pop behaviour.
REQ-032: With RAS_EMPTY_POP_GUARD_EN defined, a pop when count == 0 SHALL:
- force ras_ret_address to 0 in that cycle;
- leave ptr unchanged.
REQ-033: With RAS_EMPTY_POP_GUARD_EN undefined, a pop when count == 0 SHALL:
- return the stale stack[ptr];
- decrement ptr with wrap;
- keep count at 0.
REQ-034: In both configurations, ras_ret_address SHALL show stack[ptr] whenever no empty pop is occurring.

Verification
REQ-035: Reset, then push 0x100, 0x200, 0x300 -> ptr=3, count=3, ras_ret_address=0x300; three pops return 0x300, 0x200, 0x100; ras_empty=1.
REQ-036: Push 9 distinct values 0x1..0x9 into 8 entries -> count=8, top=0x9; 8 pops return 0x9..0x2; a 9th pop is an empty pop.
REQ-037: count=2 with top 0x20, simultaneous push 0x55 and pop -> top=0x55, count=2, ptr unchanged.
REQ-038: Save (ptr=2, count=2), push 0xAA and 0xBB, then restore_valid with push_valid high -> ptr=2, count=2, top=original entry 2, no push applied.
REQ-039: Empty pop after reset -> with the macro defined: ras_ret_address=0, ptr=0; with it undefined: ptr=7, count=0.
REQ-040: Assert nRST low mid-push while count=5 -> immediately count=0, ptr=0, ras_ret_address=0; the push is lost.
